// File: rtl/fsqrt_round_pack.sv
// fsqrt_round_pack: back end of the single-precision square-root path.
// Latches the operand at acceptance, waits out the root unit's fixed latency,
// then rounds/packs the root (or a special-case result) into an IEEE single.
module fsqrt_round_pack #(
    parameter int ROOT_LAT = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [1:0]  rm,
    input  logic [31:0] q,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result,
    output logic        invalid,
    output logic        inexact
);

    localparam int               CNT_W    = $clog2(ROOT_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_LAT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [31:0]      result_q, result_d;
    logic             invalid_q, invalid_d;
    logic             inexact_q, inexact_d;
    logic [31:0]      a_q, a_d;
    logic [1:0]       rm_q, rm_d;
    logic [33:0]      calc;

    // Round-up decision; the root is always positive so RDN never increments.
    function automatic logic round_inc(input logic [1:0] mode, input logic g,
                                       input logic st, input logic lsb);
        logic inc;
        case (mode)
            2'b00:   inc = g & (st | lsb);
            2'b10:   inc = g | st;
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

    // Returns {invalid, inexact, result} for operand op, mode and root value.
    function automatic logic [33:0] fsqrt_pack(input logic [31:0] op,
                                               input logic [1:0]  mode,
                                               input logic [31:0] root);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [8:0]  e9;
        logic [22:0] frac;
        logic        g, st, inc, carry;
        logic [31:0] res;
        logic        inv, ix;
        s   = op[31];
        e   = op[30:23];
        f   = op[22:0];
        g   = root[7];
        st  = |root[6:0];
        inc = round_inc(mode, g, st, root[8]);
        // Halve the biased exponent; odd exponents were pre-shifted by the root unit.
        e9  = e[0] ? (({1'b0, e} + 9'd127) >> 1) : (({1'b0, e} + 9'd126) >> 1);
        // A carry out of the 24-bit mantissa only happens from all-ones; the
        // 23-bit fraction add then wraps to zero on its own.
        carry = (&root[31:8]) & inc;
        frac  = root[30:8] + {22'b0, inc};
        if (carry) begin
            e9 = e9 + 9'd1;
        end
        // e9 never exceeds 191, so its top bit doubles as the zero sign bit.
        res = {e9, frac};
        inv = 1'b0;
        ix  = g | st;
        if (e == 8'hFF && f != 23'b0) begin
            res = 32'h7FC0_0000;
            inv = ~f[22];
            ix  = 1'b0;
        end else if (e == 8'h00) begin
            res = {s, 31'b0};
            ix  = 1'b0;
        end else if (s) begin
            res = 32'h7FC0_0000;
            inv = 1'b1;
            ix  = 1'b0;
        end else if (e == 8'hFF) begin
            res = 32'h7F80_0000;
            ix  = 1'b0;
        end
        return {inv, ix, res};
    endfunction

    assign calc = fsqrt_pack(a_q, rm_q, q);

    // Next-state: accept a request, count the root latency, then register the result.
    always_comb begin
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        result_d  = result_q;
        invalid_d = invalid_q;
        inexact_d = inexact_q;
        a_d       = a_q;
        rm_d      = rm_q;
        if (ena) begin
            valid_d = 1'b0;
            if (busy_q) begin
                if (cnt_q == CNT_LAST) begin
                    busy_d = 1'b0;
                    cnt_d  = '0;
                    valid_d = 1'b1;
                    {invalid_d, inexact_d, result_d} = calc;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (start) begin
                busy_d = 1'b1;
                cnt_d  = CNT_W'(1);
                a_d    = a;
                rm_d   = rm;
            end
        end
    end

    // Control and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            invalid_q <= invalid_d;
            inexact_q <= inexact_d;
        end
    end

    // Operand latch; only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        rm_q <= rm_d;
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign result  = result_q;
    assign invalid = invalid_q;
    assign inexact = inexact_q;

endmodule

// File: tb/tb_fsqrt_round_pack.sv
// Testbench for fsqrt_round_pack: directed and randomized operations checked
// against an arithmetic reference model of the square-root back end.
module tb_fsqrt_round_pack;

    localparam int LAT = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [1:0]  rm = '0;
    logic [31:0] q = '0;
    logic        busy, valid, invalid, inexact;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    fsqrt_round_pack #(.ROOT_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .a(a), .rm(rm), .q(q),
        .busy(busy), .valid(valid), .result(result), .invalid(invalid), .inexact(inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: {invalid, inexact, result} from IEEE classification and
    // integer arithmetic on the root value.
    function automatic logic [33:0] model_fsqrt(input logic [31:0] av, input logic [1:0] rmv,
                                                input logic [31:0] qv);
        int e, unb, ex, mant, rem, m, frac;
        logic inc;
        e = int'({24'b0, av[30:23]});
        if (e == 255 && av[22:0] != 0) return {~av[22], 1'b0, 32'h7FC0_0000};
        if (e == 0) return {2'b00, av[31], 31'b0};
        if (av[31]) return {2'b10, 32'h7FC0_0000};
        if (e == 255) return {2'b00, 32'h7F80_0000};
        unb  = e - 127;
        ex   = 127 + (unb >>> 1);
        mant = int'({8'b0, qv[31:8]});
        rem  = int'({24'b0, qv[7:0]});
        case (rmv)
            2'd0: inc = (rem > 128) || (rem == 128 && (mant % 2) == 1);
            2'd2: inc = (rem != 0);
            default: inc = 1'b0;
        endcase
        m = mant + (inc ? 1 : 0);
        if (m >= (1 << 24)) begin
            ex   = ex + 1;
            frac = 0;
        end else begin
            frac = m % (1 << 23);
        end
        return {1'b0, rem != 0, (32'(ex) << 23) | 32'(frac)};
    endfunction

    // Runs one operation: q carries qv only in the ena-cycle where the root is
    // due, garbage otherwise. Optional ena gap mid-flight and ena hold after valid.
    task automatic run_op(input logic [31:0] av, input logic [1:0] rmv, input logic [31:0] qv,
                          input int gap_at, input int gap_len, input int hold_len,
                          output logic [33:0] got, output int lat,
                          output logic vhold, output logic vafter, output logic acc_busy);
        int ecnt, gaps;
        ena = 1'b1; start = 1'b1; a = av; rm = rmv; q = $urandom;
        step();
        start = 1'b0; a = $urandom; rm = 2'($urandom);
        acc_busy = busy;
        lat = -1; ecnt = 1; gaps = 0; got = '0;
        for (int c = 1; c <= 200; c++) begin
            if (valid) begin
                lat = c;
                break;
            end
            if (ecnt == gap_at && gaps < gap_len) begin
                ena = 1'b0;
                gaps++;
            end else begin
                ena = 1'b1;
            end
            q = (ecnt == LAT) ? qv : $urandom;
            step();
            if (ena) ecnt++;
        end
        got = {invalid, inexact, result};
        q = $urandom;
        vhold = 1'b1;
        for (int h = 0; h < hold_len; h++) begin
            ena = 1'b0;
            step();
            if (!valid || {invalid, inexact, result} != got) vhold = 1'b0;
        end
        ena = 1'b1;
        step();
        vafter = valid;
    endtask

    task automatic test_reset();
        ena = 1'b0; rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++;
        if ({busy, valid, invalid, inexact, result} !== 36'b0) begin
            failures++;
            $display("FAIL reset_state: busy=%b valid=%b inv=%b ix=%b result=%h, expected all zero",
                     busy, valid, invalid, inexact, result);
        end
    endtask

    task automatic test_basic();
        logic [31:0] av [4] = '{32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 32'h3F00_0000};
        logic [1:0]  rv [4] = '{2'd0, 2'd0, 2'd2, 2'd0};
        logic [31:0] qv [4] = '{32'h8000_0000, 32'hB504_F333, 32'hB504_F333, 32'hFFFF_FF80};
        logic [33:0] ev [4] = '{{2'b00, 32'h4000_0000}, {2'b01, 32'h3FB5_04F3},
                                {2'b01, 32'h3FB5_04F4}, {2'b01, 32'h3F80_0000}};
        logic [33:0] got;
        int lat;
        logic vh, va, ab;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], rv[i], qv[i], 0, 0, 0, got, lat, vh, va, ab);
            checks++;
            if (got !== ev[i]) begin
                failures++;
                $display("FAIL basic_%0d: got {inv,ix,res}=%h expected %h", i, got, ev[i]);
            end
            checks++;
            if (lat != LAT + 1) begin
                failures++;
                $display("FAIL basic_latency_%0d: got %0d expected %0d", i, lat, LAT + 1);
            end
            checks++;
            if (va !== 1'b0 || ab !== 1'b1) begin
                failures++;
                $display("FAIL basic_pulse_%0d: valid_after=%b busy_at_accept=%b expected 0/1", i, va, ab);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [33:0] got;
        int lat, seen;
        logic vh, va, ab;
        ena = 1'b1; start = 1'b1; a = 32'h4080_0000; rm = 2'd0; q = $urandom;
        step();
        start = 1'b0;
        for (int i = 1; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, valid, result} !== 34'b0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b valid=%b result=%h expected 0/0/0", busy, valid, result);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_abort: got %0d valid pulses expected 0", seen);
        end
        run_op(32'h4000_0000, 2'd2, 32'hB504_F333, 0, 0, 0, got, lat, vh, va, ab);
        checks++;
        if (got !== {2'b01, 32'h3FB5_04F4} || lat != LAT + 1) begin
            failures++;
            $display("FAIL reset_recover: got %h lat=%0d expected %h lat=%0d",
                     got, lat, {2'b01, 32'h3FB5_04F4}, LAT + 1);
        end
    endtask

    task automatic test_specials();
        logic [31:0] av [6] = '{32'hBF80_0000, 32'hFF80_0001, 32'h7FC0_0001,
                                32'h8000_0000, 32'h0000_0123, 32'h7F80_0000};
        logic [33:0] ev [6] = '{{2'b10, 32'h7FC0_0000}, {2'b10, 32'h7FC0_0000},
                                {2'b00, 32'h7FC0_0000}, {2'b00, 32'h8000_0000},
                                {2'b00, 32'h0000_0000}, {2'b00, 32'h7F80_0000}};
        logic [33:0] got;
        int lat;
        logic vh, va, ab;
        for (int i = 0; i < 6; i++) begin
            run_op(av[i], 2'($urandom), 32'hDEAD_BEEF, 0, 0, 0, got, lat, vh, va, ab);
            checks++;
            if (got !== ev[i] || lat != LAT + 1) begin
                failures++;
                $display("FAIL special_%h: got %h lat=%0d expected %h lat=%0d",
                         av[i], got, lat, ev[i], LAT + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [33:0] got, exp;
        logic [31:0] av, qv;
        logic [1:0]  rv;
        int lat, cls;
        logic vh, va, ab;
        for (int i = 0; i < 40; i++) begin
            cls = int'($urandom_range(0, 9));
            av = $urandom;
            if (cls <= 5) begin
                av[31] = 1'b0;
                av[30:23] = 8'($urandom_range(1, 254));
            end else if (cls == 6) av[30:23] = 8'h00;
            else if (cls == 7) begin
                av[30:23] = 8'hFF;
                av[0] = 1'b1;
            end else if (cls == 8) begin
                av[31] = 1'b1;
                av[30:23] = 8'($urandom_range(1, 255));
            end else av = 32'h7F80_0000;
            qv = {1'b1, 31'($urandom)};
            if (i % 4 == 0) qv[7:0] = 8'h80;
            if (i % 7 == 0) qv[31:8] = 24'hFFFFFF;
            rv = 2'($urandom);
            exp = model_fsqrt(av, rv, qv);
            run_op(av, rv, qv, 0, 0, 0, got, lat, vh, va, ab);
            checks++;
            if (got !== exp || lat != LAT + 1) begin
                failures++;
                $display("FAIL random_%0d a=%h rm=%0d q=%h: got %h lat=%0d expected %h lat=%0d",
                         i, av, rv, qv, got, lat, exp, LAT + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] exp;
        int pos [$];
        int bad;
        exp = model_fsqrt(32'h4000_0000, 2'd0, 32'hB504_F333);
        ena = 1'b1; a = 32'h4000_0000; rm = 2'd0; q = 32'hB504_F333; bad = 0;
        for (int c = 0; c <= 3 * (LAT + 1) + 1; c++) begin
            if (valid) begin
                pos.push_back(c);
                if ({invalid, inexact, result} !== exp) bad++;
            end
            start = 1'b1;
            step();
        end
        start = 1'b0;
        checks++;
        if (pos.size() != 3 || pos[0] != LAT + 1 || pos[1] != 2 * (LAT + 1) || pos[2] != 3 * (LAT + 1)) begin
            failures++;
            $display("FAIL back_to_back_timing: got %0d valids first=%0d expected 3 at %0d,%0d,%0d",
                     pos.size(), (pos.size() > 0) ? pos[0] : -1, LAT + 1, 2 * (LAT + 1), 3 * (LAT + 1));
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL back_to_back_result: got %0d wrong results expected 0", bad);
        end
        for (int i = 0; i < 60 && busy; i++) step();
        step();
    endtask

    task automatic test_ena_stall();
        logic [33:0] got;
        int lat;
        logic vh, va, ab;
        run_op(32'h4000_0000, 2'd0, 32'hB504_F333, 12, 5, 3, got, lat, vh, va, ab);
        checks++;
        if (got !== {2'b01, 32'h3FB5_04F3} || lat != LAT + 1 + 5) begin
            failures++;
            $display("FAIL ena_gap: got %h lat=%0d expected %h lat=%0d",
                     got, lat, {2'b01, 32'h3FB5_04F3}, LAT + 6);
        end
        checks++;
        if (vh !== 1'b1 || va !== 1'b0) begin
            failures++;
            $display("FAIL ena_hold: valid_held=%b valid_after=%b expected 1/0", vh, va);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_specials();
        test_random();
        test_back_to_back();
        test_ena_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsqrt_round_pack.md
Name: fsqrt_round_pack

Overview:
Back-end stage of the single-precision square-root path. It captures the IEEE-754 operand when a new fsqrt is accepted and classifies it. It tracks the Newton root unit's fixed latency, then samples the unit's 32-bit normalized root (.1xxx…x, bit 0 sticky). It computes the result exponent, rounds per the requested mode, substitutes special-case results, and registers the packed IEEE result with invalid/inexact flags.

Parameters:
ROOT_LAT, 24, number of ena-qualified cycles from start acceptance until the root unit's q is valid (sampling cycle)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
ena  input  1  pipeline enable; when 0 every register holds
start  input  1  fsqrt request (ID stage)
a  input  32  IEEE single operand, sampled on acceptance
rm  input  2  rounding mode: 00 RNE, 01 RZ, 10 RUP(+inf), 11 RDN(-inf); sampled on acceptance
q  input  32  root from root unit: bit31 = 1 for normal operands, bit0 = sticky
busy  output  1  operation in flight; new start ignored
valid  output  1  result/flags valid (one ena-cycle pulse)
result  output  32  packed IEEE single result
invalid  output  1  IEEE invalid flag for this result
inexact  output  1  IEEE inexact flag for this result

Behaviour:
- Reset (rst=1 at posedge, regardless of ena): cnt=0, busy=0, valid=0, result=0, invalid=0, inexact=0. Reset during an operation aborts it; no result is produced.
- Acceptance: start & ena & !busy. On acceptance: latch a and rm, set busy=1, cnt=1. A start while busy is ignored; no error and no queueing.
- Each ena cycle while busy: cnt increments. When cnt==ROOT_LAT, sample q and compute the result. Next edge: result/flags are registered, valid=1, busy=0, cnt=0. Total latency is ROOT_LAT+1 ena-cycles from acceptance.
- valid is high for exactly one ena-advanced cycle, then clears. With ena=0 it holds its value.
- A new start is accepted in the cycle after valid at the earliest (busy already 0).
- Classification of the latched a (s, e[7:0], f[22:0]):
  - NaN (e=FF, f!=0) -> 0x7FC00000; invalid=1 iff f[22]=0 (sNaN).
  - Zero or denormal (e=0) -> {s,31'b0}, flush-to-zero; flags 0.
  - Negative nonzero, including -inf -> 0x7FC00000, invalid=1.
  - +inf -> 0x7F800000.
  - Otherwise normal path. q is ignored for every special case, but the latency is identical.
- Normal path exponent:
  - e even: the root unit was fed d={1,f}; E=(e+126)>>1.
  - e odd: the root unit was fed d={0,1,f[22:1]}; E=(e+127)>>1.
  - The f[0] drop in the odd case is accepted datapath behaviour.
  - Use 9-bit arithmetic before the shift.
- Rounding:
  - mant24=q[31:8], guard g=q[7], sticky st=|q[6:0].
  - inexact = g|st.
  - Increment when: RNE: g&(st|q[8]); RZ: 0; RUP: g|st; RDN: 0 (result is always positive).
  - mant25 = mant24 + inc. If mant25[24]=1 (carry out), frac=0 and E=E+1; else frac=mant25[22:0].
  - result = {1'b0, E[7:0], frac}. The E range is 64..190, so no overflow or underflow handling is needed.
- The sampling and the output register both advance only when ena=1. A result computed at cnt==ROOT_LAT with ena=0 is re-evaluated when ena returns; q must be stable meanwhile.

Test Plan:
1. Reset mid-operation: accept start, assert rst at cnt=10 -> busy=0, valid=0, result=0; the next start is accepted normally and yields a correct result.
2. a=0x40800000 (4.0), rm=00, bench drives q=0x80000000 at cnt==ROOT_LAT -> valid ROOT_LAT+1 cycles after acceptance, result=0x40000000, invalid=0, inexact=0.
3. a=0x40000000 (2.0), rm=00, q=0xB504F333 -> result=0x3FB504F3, inexact=1. Same operand with rm=10 -> result=0x3FB504F4.
4. Rounding carry: a=0x3F000000 (0.5, e=126), rm=00, q=0xFFFFFF80 -> result=0x3F800000, inexact=1.
5. Special cases, one per run with q=0xDEADBEEF: 0xBF800000 -> 0x7FC00000 invalid=1; 0xFF800001 -> 0x7FC00000 invalid=1; 0x7FC00001 -> 0x7FC00000 invalid=0; 0x80000000 -> 0x80000000; 0x00000123 -> 0x00000000; 0x7F800000 -> 0x7F800000. Each lands at the same latency.
6. Handshake/ena: pulse start every cycle -> only every (ROOT_LAT+1)th start is accepted, one valid per accepted start. Drop ena for 5 cycles mid-operation -> valid is delayed by exactly 5 cycles, result unchanged.
